// File: rtl/uart_pkg.sv
// uart_pkg: items shared by the UART transmitter and receiver.
//   uart_state_t : frame sequencing states
//   DATA_BITS    : payload bits per frame
//   bit_cycles() : clocks per bit for a given clock and bit rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Integer division: the bit period is truncated toward zero.
  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART.
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   clear    : holds the count at zero, so the next bit period starts
//              on the edge after clear drops
//   bit_tick : high on the last clock of each bit period
// Counts 0..BIT_CYCLES-1 and wraps; BIT_CYCLES must be >= 2.
module uart_baud_gen #(
  parameter int unsigned BIT_CYCLES = 6875
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == TERM);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   tx_data  : byte to send, captured on the accept edge
//   tx_valid : tx_data is valid
//   tx_ready : holding register empty (accept = tx_valid && tx_ready)
//   tx       : serial line, registered, idles high
//   busy     : frame in progress or byte pending
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (0) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | STOP_BITS stop bits (1); reloads from holding if a byte waits
//
// tx and busy are registered from the current state, so the line trails
// the state register by one clock; a byte accepted in IDLE reaches the
// line two clocks after the accept edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 66_000_000,
  parameter int unsigned BITRATE_BPS = 9_600,
  parameter int unsigned BIT_CYCLES  = bit_cycles(CLK_HZ, BITRATE_BPS),
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [2:0]  bit_idx_q;
  logic        tx_q;
  logic        busy_q;

  logic        bit_tick;
  logic        accept;

  assign accept   = tx_valid && !hold_full_q;
  assign tx_ready = !hold_full_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

  // Held clear in IDLE so the first bit period starts exactly on the
  // frame's START entry; back-to-back frames rely on the natural wrap.
  uart_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != IDLE) || hold_full_q;

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            state_q     <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_DATA) begin
              bit_idx_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_idx_q == LAST_STOP) begin
              bit_idx_q <= '0;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Placed last so a byte arriving on the drain edge wins.
      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Instance A: BIT_CYCLES=10, one stop bit. Instance B: BIT_CYCLES=16, two.
// Stimulus pushes expected frames (data and, where known, the edge on
// which tx falls); one monitor per instance decodes the line and checks.
module tb_uart_tx;

  localparam int BC_A = 10;
  localparam int BC_B = 16;
  localparam int SB_B = 2;

  typedef struct {
    logic [7:0] data;
    int         fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_HZ(100), .BITRATE_BPS(10), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst_a), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.CLK_HZ(160), .BITRATE_BPS(10), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst(rst_b), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  task automatic push_exp(input bit sel, input logic [7:0] d, input int fall);
    exp_t e;
    e.data = d;
    e.fall = fall;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Decodes frames on one instance's line, sampling mid-bit.
  task automatic run_monitor(input bit sel);
    int         bc, nstop, fall;
    logic       prev, cur, frame_ok;
    logic [7:0] d;
    exp_t       e;
    bc    = sel ? BC_B : BC_A;
    nstop = sel ? SB_B : 1;
    prev  = 1'b1;
    forever begin
      @(negedge clk);
      cur = line_of(sel);
      if (prev === 1'b1 && cur === 1'b0) begin
        fall = cyc - 1;
        frame_ok = 1'b1;
        repeat (bc / 2) @(negedge clk);
        if (line_of(sel) !== 1'b0) frame_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (bc) @(negedge clk);
          d[i] = line_of(sel);
        end
        for (int s = 0; s < nstop; s++) begin
          repeat (bc) @(negedge clk);
          if (line_of(sel) !== 1'b1) frame_ok = 1'b0;
        end
        if ((sel ? qb.size() : qa.size()) == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame inst=%0d data=0x%02h fall=%0d", sel, d, fall);
        end else begin
          e = sel ? qb.pop_front() : qa.pop_front();
          check(sel ? "frame_data_b" : "frame_data_a", 32'(d), 32'(e.data));
          check(sel ? "framing_b" : "framing_a", 32'(frame_ok), 32'd1);
          if (e.fall >= 0)
            check(sel ? "frame_fall_b" : "frame_fall_a", 32'(fall), 32'(e.fall));
        end
        prev = line_of(sel);
      end else begin
        prev = cur;
      end
    end
  endtask

  initial run_monitor(1'b0);
  initial run_monitor(1'b1);

  // Entered and left on a negedge; leaves tx_valid asserted.
  task automatic send(input bit sel, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    if (sel) begin valid_b = 1'b1; data_b = d; end
    else     begin valid_a = 1'b1; data_a = d; end
    while ((sel ? ready_b : ready_a) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout inst=%0d data=0x%02h", sel, d);
    end
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while (n < 4000 && ((sel ? qb.size() : qa.size()) != 0 ||
                        (sel ? busy_b : busy_a) !== 1'b0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout inst=%0d pending=%0d", sel, sel ? qb.size() : qa.size());
    end
  endtask

  // Returns the edge on which busy was first seen low.
  task automatic busy_fall_edge(input bit sel, output int edge_idx);
    int n;
    n = 0;
    while ((sel ? busy_b : busy_a) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    edge_idx = cyc - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, acc3, f1, e_busy, t_rst;

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b1; valid_b = 1'b1;
    data_a = 8'hFF; data_b = 8'hFF;

    // Reset with tx_valid held high: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx_a", 32'(tx_a), 32'd1);
      check("rst_ready_a", 32'(ready_a), 32'd1);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_tx_b", 32'(tx_b), 32'd1);
      check("rst_busy_b", 32'(busy_b), 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    repeat (3 * BC_B) @(negedge clk);
    check("post_rst_tx_a", 32'(tx_a), 32'd1);
    check("post_rst_busy_a", 32'(busy_a), 32'd0);
    check("post_rst_busy_b", 32'(busy_b), 32'd0);

    // Single byte: fall two clocks after accept, busy ends 10 bits later.
    send(1'b0, 8'h05, acc);
    valid_a = 1'b0;
    push_exp(1'b0, 8'h05, acc + 2);
    check("ready_after_accept", 32'(ready_a), 32'd0);
    while (cyc < acc + 3) @(negedge clk);
    check("busy_during_frame", 32'(busy_a), 32'd1);
    busy_fall_edge(1'b0, e_busy);
    check("busy_fall_single", 32'(e_busy), 32'(acc + 2 + 10 * BC_A));
    wait_idle(1'b0);

    // Loopback-style stream of three bytes.
    send(1'b0, 8'h05, acc); push_exp(1'b0, 8'h05, -1);
    send(1'b0, 8'h08, acc); push_exp(1'b0, 8'h08, -1);
    send(1'b0, 8'h11, acc); push_exp(1'b0, 8'h11, -1);
    valid_a = 1'b0;
    wait_idle(1'b0);

    // Back-to-back: A3 fills holding during frame 1, A5 stalls.
    send(1'b0, 8'hA1, acc);
    f1 = acc + 2;
    push_exp(1'b0, 8'hA1, f1);
    send(1'b0, 8'hA3, acc2);
    check("b2b_second_accept", 32'(acc2), 32'(acc + 2));
    check("b2b_ready_low", 32'(ready_a), 32'd0);
    push_exp(1'b0, 8'hA3, f1 + 10 * BC_A);
    send(1'b0, 8'hA5, acc3);
    check("b2b_third_accept", 32'(acc3), 32'(f1 + 10 * BC_A));
    push_exp(1'b0, 8'hA5, f1 + 20 * BC_A);
    valid_a = 1'b0;
    wait_idle(1'b0);

    // Reset during data bit 3 of 0x2B with 0x77 pending.
    send(1'b0, 8'h2B, acc);
    push_exp(1'b0, 8'hFB, acc + 2);
    send(1'b0, 8'h77, acc2);
    valid_a = 1'b0;
    check("pending_accept", 32'(acc2), 32'(acc + 2));
    t_rst = acc + 2 + 4 * BC_A + 2;
    while (cyc < t_rst) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_ready", 32'(ready_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    repeat (8 * BC_A) @(negedge clk);
    check("midrst_no_pending", 32'(busy_a), 32'd0);
    send(1'b0, 8'h30, acc);
    valid_a = 1'b0;
    push_exp(1'b0, 8'h30, acc + 2);
    wait_idle(1'b0);

    // Two stop bits, 16 clocks per bit: 176-clock frames back-to-back.
    send(1'b1, 8'h1A, acc);
    push_exp(1'b1, 8'h1A, acc + 2);
    send(1'b1, 8'h3C, acc2);
    push_exp(1'b1, 8'h3C, acc + 2 + 11 * BC_B);
    valid_b = 1'b0;
    busy_fall_edge(1'b1, e_busy);
    check("busy_fall_b", 32'(e_busy), 32'(acc + 2 + 22 * BC_B));
    wait_idle(1'b1);

    repeat (4) @(negedge clk);
    check("final_queue_a", 32'(qa.size()), 32'd0);
    check("final_queue_b", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the send-side counterpart of UART_Rec, with the same framing: idle-high line, one start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1).
- Accepts bytes on a valid/ready handshake.
- Holds one pending byte in a holding register, so frames go out back-to-back with no idle gap.
- Sits between on-chip logic and the UART pin; its output is directly loop-testable against UART_Rec.

Parameters:
CLK_HZ, 66_000_000, system clock frequency in Hz
BITRATE_BPS, 9_600, line bit rate in bits per second
BIT_CYCLES, CLK_HZ/BITRATE_BPS (6875), clocks per bit, integer division; must be >= 2
STOP_BITS, 1, number of stop bits, legal values 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send, sampled on the accept edge
tx_valid  input  1  tx_data is valid
tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready at a rising edge
tx  output  1  serial line, registered, idle 1
busy  output  1  frame in progress or byte pending

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on rst. It takes priority over all other inputs.
- Reset values:
  - tx=1, tx_ready=1, busy=0.
  - FSM in IDLE; holding register empty; bit counter and baud counter = 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If holding is full, load it into the shift register, clear holding, and go to START. This happens on the cycle after the accept edge.
  - If a byte is accepted while in IDLE, tx falls exactly 2 clocks after the accept edge: one cycle to load holding, one cycle for the registered tx.
- START: tx=0 for BIT_CYCLES clocks, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for BIT_CYCLES clocks per bit, then shift right.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*BIT_CYCLES clocks.
  - At the end, if holding is full, load it and enter START on the same edge. There is no extra idle cycle between frames.
  - Otherwise go to IDLE.
- Frame length: exactly (9+STOP_BITS)*BIT_CYCLES clocks of line time.
- Baud counter:
  - Counts 0..BIT_CYCLES-1; bit_tick pulses at the terminal count.
  - Cleared on every state entry from IDLE, so bit boundaries are aligned to the frame start.
  - Width: $clog2(BIT_CYCLES).
- Handshake:
  - tx_ready = holding empty.
  - A byte may be accepted in any state, including on the same edge that holding is drained. In that case the new byte is stored, tx_ready stays high that cycle and drops the next cycle.
  - tx_valid without tx_ready is ignored; upstream holds the byte.
  - tx_data need not be stable after the accept edge.
- busy = (state != IDLE) || holding full.
- Reset mid-frame:
  - tx=1 on the next edge; pending byte discarded.
  - A truncated frame is acceptable; the receiver sees it as a framing error.

Decomposition:
- Package uart_pkg holds:
  - state typedef uart_state_t {IDLE, START, DATA, STOP};
  - constant DATA_BITS=8;
  - function bit_cycles(clk_hz, bps).
- UART_Rec should migrate to the same package.
- One sub-module, uart_baud_gen:
  - Inputs: clk, rst, clear.
  - Output: bit_tick.
  - Parameter: BIT_CYCLES.
  - Reusable by the receiver.
- FSM, shift register and holding register stay in uart_tx.

Test Plan:
- Reset:
  - Stimulus: hold rst 3 cycles with tx_valid=1.
  - Required: tx=1, tx_ready=1, busy=0 throughout; no frame starts after release until a new accept.
- Single byte 0x05, default parameters:
  - Stimulus: send 0x05.
  - Required: tx low starting 2 clocks after accept, for 6875 clocks; then bits 1,0,1,0,0,0,0,0, 6875 clocks each; then high.
  - Required: busy deasserts 68750 clocks after tx falls.
- Loopback to UART_Rec:
  - Stimulus: send 0x05, 0x08, 0x11 through uart_tx.tx into UART_Rec.rx.
  - Required: UART_Rec pulses data_valid with data 0x05, 0x08, 0x11, in order.
- Back-to-back:
  - Stimulus: offer 0xA1 then 0xA3 immediately.
  - Required: the second is accepted during frame 1; frame 2 start bit begins the clock after frame 1's stop bit ends; 20*6875 clocks total line time; tx_ready low while holding is full.
  - Required: a third byte 0xA5 offered during frame 1 stalls (tx_ready=0) until frame 2 loads.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3 of 0x2B.
  - Required: tx=1 the next clock; pending byte lost; a new byte 0x30 afterwards is framed correctly.
- STOP_BITS=2, BIT_CYCLES=16 fast configuration:
  - Stimulus: send 0x1A.
  - Required: frame is 11*16=176 clocks; stop high for 32 clocks.
